level_generator: RTL and testbench
==================================

# level_generator

Drives a clean, glitch-free output level from single-cycle set/clear/toggle request strobes, enforcing a minimum hold time after every transition. It is the transmit-side counterpart of the input edge detection path: firmware and controller logic issue edge-style events, and this block turns them into a rate-limited level for an external pin or a downstream synchronous consumer. One instance per driven line.

## Interface

- `HOLD_CYCLES`, default 4: minimum number of cycles the level is held after each change; legal range ≥ 1.
- `INITIAL_LEVEL`, default LOW: value of `level` in reset.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `set_req` input 1: one-cycle strobe; target level HIGH.
- `clear_req` input 1: one-cycle strobe; target level LOW.
- `toggle_req` input 1: one-cycle strobe; target is the inverse of the effective level.
- `level` output 1: registered output level.
- `changed` output 1: registered; high for exactly the first cycle of a new `level` value.
- `ready` output 1: registered; high when no hold is in progress.
- `dropped` output 1: registered one-cycle pulse when a request is discarded.

## Operation

- Request priority within one cycle: `clear_req` > `set_req` > `toggle_req`; lower-priority strobes in the same cycle are ignored silently, without `dropped`.
- Effective level: the pending target if a pending slot is valid, otherwise `level`. Toggle target is the inverse of the effective level.
- States: IDLE and HOLD.
- IDLE, request with target ≠ `level`:
  - `level` takes the target.
  - `changed` is set.
  - Counter loads `HOLD_CYCLES-1`.
  - State moves to HOLD.
- IDLE, request with target = `level`: no-op. No `changed`, no hold.
- HOLD: counter decrements each cycle. A request arriving here is handled per Configuration.
- HOLD expiry (counter = 0):
  - If a request is present this cycle, it is used. Otherwise the pending slot is used, if valid.
  - If the target ≠ `level`: apply it, reload the counter, stay in HOLD.
  - Otherwise: go to IDLE.
  - The pending slot is cleared in all cases.
- Reset, at any time including mid-hold, aborts everything:
  - `level` = `INITIAL_LEVEL`, `ready` = 1, `changed` = 0, `dropped` = 0.
  - Pending slot cleared, counter = 0, state IDLE.

## Timing

- A request sampled at the edge ending cycle n gives:
  - new `level` and `changed` = 1 in cycle n+1.
  - `ready` = 0 in cycles n+1 … n+`HOLD_CYCLES`.
  - `ready` = 1 again in cycle n+`HOLD_CYCLES`+1 if nothing is pending.
- Back-to-back changes: the minimum spacing between `level` transitions is exactly `HOLD_CYCLES` cycles. A pending or final-hold-cycle request changes `level` in cycle n+`HOLD_CYCLES`+1 with no idle gap.
- `HOLD_CYCLES` = 1: `ready` is low for one cycle after each change. A toggle strobe held high continuously produces a square wave with period 2.
- `changed` is never high for two consecutive cycles unless `HOLD_CYCLES` = 1 with continuous changes.
- `dropped` occurs in the cycle after the discarding request.

## Configuration

- `LEVEL_GENERATOR_PENDING_EN` defined:
  - Requests arriving during HOLD (other than the expiry cycle) are stored in a one-deep pending slot.
  - A newer request overwrites the slot and pulses `dropped`.
  - A toggle evaluates against the pending target.
- Not defined:
  - There is no pending slot.
  - Any request during HOLD before the expiry cycle is discarded and pulses `dropped`.
  - Only requests in IDLE or in the expiry cycle take effect.
  - Port list is identical in both builds.

## Structure

- Shared package holds:
  - the `HIGH`/`LOW` constants already used across the design;
  - `level_generator_state_t` (IDLE, HOLD).
- `HOLD_CYCLES` counter width is a local derivation: `$clog2(HOLD_CYCLES)`, minimum 1.
- One sub-module is natural: `hold_timer` (load / decrement / expired), reusable by other rate-limited outputs.
- Target resolution and priority stay in the top module.

## Test plan

- Reset: `INITIAL_LEVEL` = LOW, pulse `set_req` at cycle 5 → `level` = 1 and `changed` = 1 at cycle 6; `ready` = 0 for cycles 6–9, 1 at cycle 10.
- Same-level request: with `level` = 1 and IDLE, pulse `set_req` → no `changed`, `ready` stays 1, `dropped` = 0.
- Priority: `set_req`, `clear_req` and `toggle_req` together while `level` = 1 → `level` = 0 next cycle, exactly one `changed`.
- Pending (macro on): set at cycle 0, toggle at cycle 2, toggle at cycle 3 → `dropped` at cycle 4; second toggle resolves to HIGH = `level`, so no change at cycle 5 and `ready` = 1 at cycle 6.
- Drop (macro off): set at cycle 0, clear at cycle 2 → `dropped` at cycle 3; `level` stays 1.
- Expiry-cycle request: clear at the cycle where the counter = 0 → `level` = 0 exactly `HOLD_CYCLES` cycles after the previous change.
- Reset mid-hold: assert `reset` asynchronously during HOLD → `level`, `ready`, `changed` and `dropped` reach their reset values immediately; no pending action after release.

Source files
------------

// File: rtl/level_generator_pkg.sv
// Shared level constants and the level_generator state encoding.
package level_generator_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } level_generator_state_t;

endpackage

// File: rtl/level_generator_hold_timer.sv
// Hold timer: load to HOLD_CYCLES-1, count down to zero, flag expiry while at zero.
// Reusable by any rate-limited output that needs a minimum dwell time.
module level_generator_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  output logic expired_o
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/level_generator.sv
// Rate-limited level driver from set/clear/toggle strobes with a minimum hold after each change.
// LEVEL_GENERATOR_PENDING_EN adds a one-deep pending slot for requests arriving mid-hold.
module level_generator
  import level_generator_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter logic        INITIAL_LEVEL = LOW
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic set_req_i,
  input  logic clear_req_i,
  input  logic toggle_req_i,
  output logic level_o,
  output logic changed_o,
  output logic ready_o,
  output logic dropped_o
);

  level_generator_state_t state_q, state_d;
  logic level_q, level_d;
  logic changed_q, changed_d;
  logic ready_q, ready_d;
  logic dropped_q, dropped_d;
  logic pend_vld_q, pend_vld_d;
  logic pend_lvl_q, pend_lvl_d;

  logic load;
  logic expired;
  logic req_vld;
  logic eff_lvl;
  logic tgt_lvl;
  logic nxt_vld;
  logic nxt_lvl;

  level_generator_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (load),
    .expired_o(expired)
  );

  // Priority clear > set > toggle; a toggle inverts whatever level is already queued.
  assign req_vld = clear_req_i | set_req_i | toggle_req_i;
  assign eff_lvl = pend_vld_q ? pend_lvl_q : level_q;
  assign tgt_lvl = clear_req_i ? LOW : (set_req_i ? HIGH : ~eff_lvl);
  assign nxt_vld = req_vld | pend_vld_q;
  assign nxt_lvl = req_vld ? tgt_lvl : pend_lvl_q;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    changed_d  = 1'b0;
    dropped_d  = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_lvl_d = pend_lvl_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_vld && (tgt_lvl != level_q)) begin
          level_d   = tgt_lvl;
          changed_d = 1'b1;
          load      = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (expired) begin
          pend_vld_d = 1'b0;
          if (nxt_vld && (nxt_lvl != level_q)) begin
            level_d   = nxt_lvl;
            changed_d = 1'b1;
            load      = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (req_vld) begin
`ifdef LEVEL_GENERATOR_PENDING_EN
          dropped_d  = pend_vld_q;
          pend_vld_d = 1'b1;
          pend_lvl_d = tgt_lvl;
`else
          dropped_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      level_q    <= INITIAL_LEVEL;
      changed_q  <= 1'b0;
      ready_q    <= 1'b1;
      dropped_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_lvl_q <= LOW;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      changed_q  <= changed_d;
      ready_q    <= ready_d;
      dropped_q  <= dropped_d;
      pend_vld_q <= pend_vld_d;
      pend_lvl_q <= pend_lvl_d;
    end
  end

  assign level_o   = level_q;
  assign changed_o = changed_q;
  assign ready_o   = ready_q;
  assign dropped_o = dropped_q;

endmodule

// File: tb/tb_level_generator.sv
// Bench for level_generator: two instances (hold 4 and hold 1) against a time-based reference model.
module tb_level_generator;

  localparam int H0 = 4;
  localparam int H1 = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic set_req = 1'b0;
  logic clear_req = 1'b0;
  logic toggle_req = 1'b0;

  logic level0, changed0, ready0, dropped0;
  logic level1, changed1, ready1, dropped1;
  logic [3:0] obs [2];

  int errors = 0;
  int checks = 0;

  // Reference model: level, cycle in which the current level began, pending slot.
  int cyc = 0;
  bit m_lvl [2];
  int m_tchg [2];
  bit m_pv [2];
  bit m_pl [2];
  bit m_chg [2];
  bit m_drp [2];

  always #5 clk = ~clk;

  level_generator #(.HOLD_CYCLES(H0), .INITIAL_LEVEL(1'b0)) dut0 (
    .clk_i(clk), .reset_i(reset), .set_req_i(set_req), .clear_req_i(clear_req),
    .toggle_req_i(toggle_req), .level_o(level0), .changed_o(changed0),
    .ready_o(ready0), .dropped_o(dropped0)
  );

  level_generator #(.HOLD_CYCLES(H1), .INITIAL_LEVEL(1'b0)) dut1 (
    .clk_i(clk), .reset_i(reset), .set_req_i(set_req), .clear_req_i(clear_req),
    .toggle_req_i(toggle_req), .level_o(level1), .changed_o(changed1),
    .ready_o(ready1), .dropped_o(dropped1)
  );

  assign obs[0] = {level0, changed0, ready0, dropped0};
  assign obs[1] = {level1, changed1, ready1, dropped1};

  function automatic int hold_of(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  // Expected {level, changed, ready, dropped} for the current cycle.
  function automatic logic [3:0] exp_of(input int i);
    logic rdy;
    rdy = (cyc >= m_tchg[i] + hold_of(i));
    return {m_lvl[i], m_chg[i], rdy, m_drp[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 1'b0; m_tchg[i] = -100; m_pv[i] = 1'b0; m_pl[i] = 1'b0;
      m_chg[i] = 1'b0; m_drp[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit c, input bit s, input bit t);
    int h;
    bit busy, expiry, req, eff, tgt, has, nt;
    h = hold_of(i);
    busy = (cyc < m_tchg[i] + h);
    expiry = (cyc == m_tchg[i] + h - 1);
    req = c | s | t;
    eff = m_pv[i] ? m_pl[i] : m_lvl[i];
    tgt = c ? 1'b0 : (s ? 1'b1 : ~eff);
    m_chg[i] = 1'b0; m_drp[i] = 1'b0; has = 1'b0; nt = m_lvl[i];
    if (!busy) begin
      has = req; nt = tgt;
    end else if (expiry) begin
      has = req | m_pv[i];
      nt = req ? tgt : m_pl[i];
      m_pv[i] = 1'b0;
    end else if (req) begin
`ifdef LEVEL_GENERATOR_PENDING_EN
      m_drp[i] = m_pv[i]; m_pv[i] = 1'b1; m_pl[i] = tgt;
`else
      m_drp[i] = 1'b1;
`endif
    end
    if (has && (nt != m_lvl[i])) begin
      m_lvl[i] = nt; m_chg[i] = 1'b1; m_tchg[i] = cyc + 1;
    end
  endtask

  // Present strobes for one cycle; returns #1 after the edge that sampled them.
  task automatic cycle(input bit c, input bit s, input bit t);
    clear_req = c; set_req = s; toggle_req = t;
    @(posedge clk);
    model_step(0, c, s, t);
    model_step(1, c, s, t);
    cyc++;
    #1;
    clear_req = 1'b0; set_req = 1'b0; toggle_req = 1'b0;
  endtask

  task automatic go_idle(input bit lvl);
    for (int r = 0; r < 2; r++) begin
      cycle(~lvl, lvl, 1'b0);
      for (int k = 0; k < H0 + 1; k++) cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if (obs[0] !== 4'b0010 || obs[1] !== 4'b0010) begin
      errors++;
      $display("FAIL reset_values got %b/%b exp 0010", obs[0], obs[1]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_set_timing();
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs[0] !== 4'b1100) begin
      errors++; $display("FAIL set_first_cycle got %b exp 1100", obs[0]);
    end
    for (int k = 0; k < H0; k++) begin
      if (k > 0) begin
        checks++;
        if (obs[0] !== 4'b1000) begin
          errors++; $display("FAIL set_hold k=%0d got %b exp 1000", k, obs[0]);
        end
      end
      checks++;
      if (obs[1] !== exp_of(1)) begin
        errors++; $display("FAIL set_timing_h1 k=%0d got %b exp %b", k, obs[1], exp_of(1));
      end
      cycle(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (obs[0] !== 4'b1010) begin
      errors++; $display("FAIL set_ready_again got %b exp 1010", obs[0]);
    end
  endtask

  task automatic test_same_level();
    go_idle(1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 4'b1010) begin
        errors++; $display("FAIL same_level dut%0d got %b exp 1010", i, obs[i]);
      end
    end
  endtask

  task automatic test_priority();
    int pulses;
    go_idle(1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    pulses = 0;
    checks++;
    if (obs[0] !== 4'b0100) begin
      errors++; $display("FAIL priority_first got %b exp 0100", obs[0]);
    end
    for (int k = 0; k < 6; k++) begin
      pulses += int'(changed0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (pulses != 1 || level0 !== 1'b0) begin
      errors++; $display("FAIL priority_pulses got %0d lvl %b exp 1 lvl 0", pulses, level0);
    end
  endtask

  task automatic test_hold_request();
    go_idle(1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
`ifdef LEVEL_GENERATOR_PENDING_EN
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (dropped0 !== 1'b1) begin
      errors++; $display("FAIL pending_overwrite_drop got %b exp 1", dropped0);
    end
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (level0 !== 1'b1 || changed0 !== 1'b0) begin
      errors++; $display("FAIL pending_same_level got lvl %b chg %b exp 1 0", level0, changed0);
    end
`else
    cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (dropped0 !== 1'b1 || level0 !== 1'b1) begin
      errors++; $display("FAIL hold_drop got drp %b lvl %b exp 1 1", dropped0, level0);
    end
    cycle(1'b0, 1'b0, 1'b0);
`endif
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs[0] !== 4'b1010) begin
      errors++; $display("FAIL hold_request_end got %b exp 1010", obs[0]);
    end
  endtask

  task automatic test_expiry_request();
    go_idle(1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < H0 - 1; k++) cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (level0 !== 1'b1) begin
      errors++; $display("FAIL expiry_before got %b exp 1", level0);
    end
    cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs[0] !== 4'b0100) begin
      errors++; $display("FAIL expiry_change got %b exp 0100", obs[0]);
    end
  endtask

  task automatic test_square_wave();
    go_idle(1'b0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      checks++;
      if (level1 !== ((k % 2) == 0) || changed1 !== 1'b1 || ready1 !== 1'b0) begin
        errors++;
        $display("FAIL square k=%0d got lvl %b chg %b rdy %b exp %b 1 0",
                 k, level1, changed1, ready1, (k % 2) == 0);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    go_idle(1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 4'b0010) begin
        errors++; $display("FAIL reset_mid_hold dut%0d got %b exp 0010", i, obs[i]);
      end
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < H0 + 2; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs[0] !== 4'b0010) begin
        errors++; $display("FAIL after_reset k=%0d got %b exp 0010", k, obs[0]);
      end
    end
  endtask

  task automatic test_random();
    bit c, s, t;
    for (int k = 0; k < 400; k++) begin
      c = ($urandom_range(5) == 0);
      s = ($urandom_range(3) == 0);
      t = ($urandom_range(3) == 0);
      cycle(c, s, t);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_of(i)) begin
          errors++;
          $display("FAIL random k=%0d dut%0d got %b exp %b", k, i, obs[i], exp_of(i));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_set_timing();
    test_same_level();
    test_priority();
    test_hold_request();
    test_expiry_request();
    test_square_wave();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
